// File: rtl/wb_dmem_pkg.sv
// Shared definitions for the Wishbone data-memory controller.
//   - state_t       : controller FSM state encoding (IDLE/WAIT/RESP)
//   - WCNT_W        : width of the wait-state down-counter
//   - DATA_W_*      : legal bus widths
//   - WAIT_*        : legal wait-state range
//   - byte_count()  : number of byte lanes for a given data width
package wb_dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int WCNT_W     = 3;
  localparam int DATA_W_MIN = 32;
  localparam int DATA_W_MAX = 64;
  localparam int WAIT_MIN   = 0;
  localparam int WAIT_MAX   = 7;

  function automatic int byte_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_dmem_if.sv
// Wishbone classic slave bus bundle for wb_dmem_ctrl.
//   cyc_i/stb_i : cycle and strobe from the master
//   adr_i       : byte address
//   we_i        : write enable
//   sel_i       : byte lane enables (DATA_W/8 bits)
//   dat_i       : write data
//   dat_o       : registered read data
//   ack_o/err_o : one-cycle normal / error termination
// The master modport drives requests, the slave modport drives responses.
interface wb_dmem_if #(
  parameter int DATA_W = 32
);
  logic                  cyc_i;
  logic                  stb_i;
  logic [31:0]           adr_i;
  logic                  we_i;
  logic [DATA_W/8-1:0]   sel_i;
  logic [DATA_W-1:0]     dat_i;
  logic [DATA_W-1:0]     dat_o;
  logic                  ack_o;
  logic                  err_o;

  modport master (
    output cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/dmem_ram.sv
// Byte-enabled word storage for wb_dmem_ctrl.
// Synchronous write of the enabled lanes, combinational read of the addressed
// word; the controller owns the output register. Contents are never reset.
// Optional feature macro: WB_DMEM_PARITY_EN adds one even-parity bit per byte,
// written with the byte, and flags a parity error on any enabled lane.
// Ports:
//   clk_i   : clock
//   i_we    : write strobe for this edge
//   i_addr  : word index
//   i_sel   : byte lanes to write / to parity-check
//   i_wdata : write data
//   o_rdata : word at i_addr
//   o_perr  : parity error on an enabled lane (always 0 without the macro)
module dmem_ram
  import wb_dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                    clk_i,
  input  logic                    i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W/8-1:0]     i_sel,
  input  logic [DATA_W-1:0]       i_wdata,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_perr
);
  localparam int NB = byte_count(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Lane-masked write; unselected bytes keep their previous contents.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_sel[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

`ifdef WB_DMEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_calc;

  // Parity bit makes each stored byte+bit hold an even number of ones.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_sel[b]) r_par[i_addr][b] <= ^i_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_calc = '0;
    for (int b = 0; b < NB; b++) w_calc[b] = ^o_rdata[8*b +: 8];
  end

  assign o_perr = |(i_sel & (w_calc ^ r_par[i_addr]));
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/wb_dmem_ctrl.sv
// Wishbone classic data-memory slave with programmable wait states.
// A request is latched in IDLE, optionally held in WAIT for WAIT_STATES
// cycles, and answered in RESP with a one-cycle ack_o or err_o. The memory
// write and the read-data capture both happen on the edge that enters RESP.
// Optional feature macro: WB_DMEM_PARITY_EN (parity-checked reads raise err_o).
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : wb_dmem_if slave modport (cyc/stb/adr/we/sel/dat in, dat/ack/err out)
module wb_dmem_ctrl
  import wb_dmem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  wb_dmem_if.slave bus
);
  localparam int NB  = byte_count(DATA_W);
  localparam int LSB = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * NB);
  localparam logic [WCNT_W-1:0] CNT_LOAD =
    (WAIT_STATES == 0) ? '0 : WCNT_W'(WAIT_STATES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [WCNT_W-1:0]   r_cnt;
  logic [31:0]         r_adr;
  logic                r_we;
  logic [NB-1:0]       r_sel;
  logic [DATA_W-1:0]   r_dat;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_err;

  logic                w_idle;
  logic                w_accept;
  logic [31:0]         w_adr;
  logic                w_we;
  logic [NB-1:0]       w_sel;
  logic [DATA_W-1:0]   w_dat;
  logic [31:0]         w_off;
  logic                w_in_range;
  logic [AW-1:0]       w_idx;
  logic                w_complete;
  logic                w_resp_err;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_perr;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && bus.cyc_i && bus.stb_i;

  // With no wait states RESP is entered on the accept edge itself, before the
  // request registers are loaded, so the live bus feeds the memory in IDLE.
  assign w_adr = w_idle ? bus.adr_i : r_adr;
  assign w_we  = w_idle ? bus.we_i  : r_we;
  assign w_sel = w_idle ? bus.sel_i : r_sel;
  assign w_dat = w_idle ? bus.dat_i : r_dat;

  // Subtraction wraps for addresses below the base, which the first term rejects.
  assign w_off      = w_adr - BASE_ADDR;
  assign w_in_range = (w_adr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx      = w_off[LSB +: AW];

  assign w_complete = (w_next == S_RESP);
  assign w_resp_err = !w_in_range || (!w_we && w_perr);

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .i_we    (w_complete && w_we && w_in_range),
    .i_addr  (w_idx),
    .i_sel   (w_sel),
    .i_wdata (w_dat),
    .o_rdata (w_rdata),
    .o_perr  (w_perr)
  );

  // Next-state logic; dropping cyc_i while waiting abandons the transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!bus.cyc_i)        w_next = S_IDLE;
        else if (r_cnt == '0)  w_next = S_RESP;
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter, request capture and registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_next == S_WAIT) r_cnt <= CNT_LOAD;
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - WCNT_W'(1);
      if (w_accept) begin
        r_adr <= bus.adr_i;
        r_we  <= bus.we_i;
        r_sel <= bus.sel_i;
        r_dat <= bus.dat_i;
      end
      r_ack <= w_complete && !w_resp_err;
      r_err <= w_complete && w_resp_err;
      // Only in-range reads refresh dat_o; parity failures still show raw data.
      if (w_complete && !w_we && w_in_range) r_rdata <= w_rdata;
    end
  end

  assign bus.dat_o = r_rdata;
  assign bus.ack_o = r_ack;
  assign bus.err_o = r_err;

endmodule

// File: tb/tb_wb_dmem_ctrl.sv
// Self-checking bench for wb_dmem_ctrl.
// uA: DATA_W=32, DEPTH=1024, WAIT_STATES=0, BASE_ADDR=0
// uB: DATA_W=32, DEPTH=16,   WAIT_STATES=3, BASE_ADDR=0x1000
// Optional feature macro exercised when defined: WB_DMEM_PARITY_EN.
module tb_wb_dmem_ctrl;

  typedef struct packed {
    logic [1:0]  unit;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } op_t;

  typedef struct {
    bit          isErr;
    int          lat;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nCmp;
  int   nBad;
  exp_t sbq[$];

  logic [31:0] mdl [int];
  logic [31:0] lastRd [2];

  wb_dmem_if #(.DATA_W(32)) busA ();
  wb_dmem_if #(.DATA_W(32)) busB ();

  wb_dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000))
    uA (.clk_i(clk), .rst_ni(rst_n), .bus(busA));

  wb_dmem_ctrl #(.DATA_W(32), .DEPTH(16), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000))
    uB (.clk_i(clk), .rst_ni(rst_n), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if a wait is never satisfied.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] baseOf(input int unit);
    return (unit == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic logic [31:0] spanOf(input int unit);
    return (unit == 0) ? 32'h0000_1000 : 32'h0000_0040;
  endfunction

  function automatic int wsOf(input int unit);
    return (unit == 0) ? 0 : 3;
  endfunction

  // Reference model: word memory plus the last value each unit returned.
  function automatic void modelOp(input op_t op, output exp_t e);
    int          unit;
    logic [31:0] off;
    logic [31:0] word;
    bit          inR;
    int          key;
    unit = int'(op.unit);
    off  = op.adr - baseOf(unit);
    inR  = (op.adr >= baseOf(unit)) && (off < spanOf(unit));
    key  = unit * 65536 + int'(off >> 2);
    if (inR && op.we) begin
      word = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (op.sel[b]) word[8*b +: 8] = op.dat[8*b +: 8];
      mdl[key] = word;
    end
    if (inR && !op.we) lastRd[unit] = mdl.exists(key) ? mdl[key] : 32'h0;
    e.isErr = !inR;
    e.lat   = wsOf(unit) + 1;
    e.data  = lastRd[unit];
    e.name  = $sformatf("u%0d %s @%h sel=%h", unit, op.we ? "wr" : "rd", op.adr, op.sel);
  endfunction

  task automatic applyStimulus(input int unit, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (unit == 0) begin
      busA.cyc_i = cyc; busA.stb_i = stb; busA.we_i = we;
      busA.adr_i = adr; busA.sel_i = sel; busA.dat_i = dat;
    end else begin
      busB.cyc_i = cyc; busB.stb_i = stb; busB.we_i = we;
      busB.adr_i = adr; busB.sel_i = sel; busB.dat_i = dat;
    end
  endtask

  task automatic sampleBus(input int unit, output bit ack, output bit err, output logic [31:0] dat);
    if (unit == 0) begin ack = busA.ack_o; err = busA.err_o; dat = busA.dat_o; end
    else           begin ack = busB.ack_o; err = busB.err_o; dat = busB.dat_o; end
  endtask

  // One transfer; request fields are scrambled after acceptance so the DUT
  // must work from what it latched. oLat counts cycles from strobe to response.
  task automatic runXfer(input int unit, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output bit oAck, output bit oErr, output int oLat,
                         output logic [31:0] oDat, output bit oStuck);
    bit a, e;
    logic [31:0] d;
    oAck = 0; oErr = 0; oLat = 99; oDat = 32'h0; oStuck = 0;
    @(negedge clk);
    applyStimulus(unit, 1'b1, 1'b1, we, adr, sel, dat);
    @(posedge clk); #1;
    applyStimulus(unit, 1'b1, 1'b0, ~we, ~adr, ~sel, ~dat);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sampleBus(unit, a, e, d);
      if (a || e) begin oAck = a; oErr = e; oLat = c; oDat = d; break; end
    end
    applyStimulus(unit, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    sampleBus(unit, a, e, d);
    oStuck = a | e;
  endtask

  task automatic runOp(input op_t op, output bit oAck, output bit oErr, output int oLat,
                       output logic [31:0] oDat, output bit oStuck);
    exp_t e;
    modelOp(op, e);
    sbq.push_back(e);
    runXfer(int'(op.unit), op.we, op.adr, op.sel, op.dat, oAck, oErr, oLat, oDat, oStuck);
  endtask

  task automatic test_reset();
    bit a, e;
    logic [31:0] d;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      sampleBus(u, a, e, d);
      nCmp++; if (a !== 1'b0) begin nBad++; $display("[TB] FAIL reset u%0d ack_o: got %0b want 0", u, a); end
      nCmp++; if (e !== 1'b0) begin nBad++; $display("[TB] FAIL reset u%0d err_o: got %0b want 0", u, e); end
      nCmp++; if (d !== 32'h0) begin nBad++; $display("[TB] FAIL reset u%0d dat_o: got %h want 0", u, d); end
      lastRd[u] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    op_t tbl[10];
    bit oAck, oErr, oStuck; int oLat; logic [31:0] oDat; exp_t e;
    tbl = '{ '{2'd0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF},
             '{2'd0, 1'b0, 32'h10,   4'hF, 32'h0},
             '{2'd0, 1'b1, 32'h10,   4'h1, 32'h000000AA},
             '{2'd0, 1'b1, 32'h10,   4'h8, 32'h55000000},
             '{2'd0, 1'b0, 32'h10,   4'hF, 32'h0},
             '{2'd0, 1'b1, 32'h10,   4'h0, 32'hFFFFFFFF},
             '{2'd0, 1'b0, 32'h13,   4'hF, 32'h0},
             '{2'd0, 1'b1, 32'hFFC,  4'hF, 32'h0BADF00D},
             '{2'd0, 1'b0, 32'hFFC,  4'hF, 32'h0},
             '{2'd0, 1'b0, 32'h1000, 4'hF, 32'h0} };
    for (int i = 0; i < 10; i++) begin
      runOp(tbl[i], oAck, oErr, oLat, oDat, oStuck);
      e = sbq.pop_front();
      nCmp++; if ({oAck, oErr} !== {!e.isErr, e.isErr}) begin nBad++; $display("[TB] FAIL %s resp: got ack=%0b err=%0b want ack=%0b err=%0b", e.name, oAck, oErr, !e.isErr, e.isErr); end
      nCmp++; if (oLat !== e.lat) begin nBad++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, oLat, e.lat); end
      nCmp++; if (oDat !== e.data) begin nBad++; $display("[TB] FAIL %s dat_o: got %h want %h", e.name, oDat, e.data); end
      nCmp++; if (oStuck !== 1'b0) begin nBad++; $display("[TB] FAIL %s pulse: response still high next cycle", e.name); end
    end
  endtask

  task automatic test_wait_states();
    op_t tbl[4];
    bit oAck, oErr, oStuck; int oLat; logic [31:0] oDat; exp_t e;
    tbl = '{ '{2'd1, 1'b1, 32'h1004, 4'hF, 32'hCAFEF00D},
             '{2'd1, 1'b0, 32'h1004, 4'hF, 32'h0},
             '{2'd1, 1'b1, 32'h1004, 4'h2, 32'h00005500},
             '{2'd1, 1'b0, 32'h1004, 4'hF, 32'h0} };
    for (int i = 0; i < 4; i++) begin
      runOp(tbl[i], oAck, oErr, oLat, oDat, oStuck);
      e = sbq.pop_front();
      nCmp++; if ({oAck, oErr} !== {!e.isErr, e.isErr}) begin nBad++; $display("[TB] FAIL %s resp: got ack=%0b err=%0b want ack=%0b err=%0b", e.name, oAck, oErr, !e.isErr, e.isErr); end
      nCmp++; if (oLat !== e.lat) begin nBad++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, oLat, e.lat); end
      nCmp++; if (oDat !== e.data) begin nBad++; $display("[TB] FAIL %s dat_o: got %h want %h", e.name, oDat, e.data); end
      nCmp++; if (oStuck !== 1'b0) begin nBad++; $display("[TB] FAIL %s pulse: response still high next cycle", e.name); end
    end
  endtask

  task automatic test_range();
    op_t tbl[9];
    bit oAck, oErr, oStuck; int oLat; logic [31:0] oDat; exp_t e;
    tbl = '{ '{2'd1, 1'b1, 32'h1000, 4'hF, 32'h11111111},
             '{2'd1, 1'b1, 32'h103C, 4'hF, 32'h22222222},
             '{2'd1, 1'b0, 32'h103C, 4'hF, 32'h0},
             '{2'd1, 1'b1, 32'h1040, 4'hF, 32'h33333333},
             '{2'd1, 1'b1, 32'h0FFC, 4'hF, 32'h44444444},
             '{2'd1, 1'b0, 32'h1040, 4'hF, 32'h0},
             '{2'd1, 1'b0, 32'h1000, 4'hF, 32'h0},
             '{2'd1, 1'b0, 32'h0FFC, 4'hF, 32'h0},
             '{2'd1, 1'b0, 32'h103C, 4'hF, 32'h0} };
    for (int i = 0; i < 9; i++) begin
      runOp(tbl[i], oAck, oErr, oLat, oDat, oStuck);
      e = sbq.pop_front();
      nCmp++; if ({oAck, oErr} !== {!e.isErr, e.isErr}) begin nBad++; $display("[TB] FAIL %s resp: got ack=%0b err=%0b want ack=%0b err=%0b", e.name, oAck, oErr, !e.isErr, e.isErr); end
      nCmp++; if (oLat !== e.lat) begin nBad++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, oLat, e.lat); end
      nCmp++; if (oDat !== e.data) begin nBad++; $display("[TB] FAIL %s dat_o: got %h want %h", e.name, oDat, e.data); end
      nCmp++; if (oStuck !== 1'b0) begin nBad++; $display("[TB] FAIL %s pulse: response still high next cycle", e.name); end
    end
  endtask

  task automatic test_abort();
    op_t tbl[2];
    bit oAck, oErr, oStuck, a, er, seen; int oLat; logic [31:0] oDat, d; exp_t e;
    tbl = '{ '{2'd1, 1'b1, 32'h1008, 4'hF, 32'h5A5A1234},
             '{2'd1, 1'b0, 32'h1008, 4'hF, 32'h0} };
    runOp(tbl[0], oAck, oErr, oLat, oDat, oStuck);
    e = sbq.pop_front();
    nCmp++; if (oAck !== 1'b1) begin nBad++; $display("[TB] FAIL %s resp: got ack=%0b want 1", e.name, oAck); end
    // Write that loses cyc_i in its second wait cycle must vanish silently.
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h1008, 4'hF, 32'hFFFF0000);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h1008, 4'hF, 32'hFFFF0000);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); sampleBus(1, a, er, d);
      if (a || er) seen = 1;
    end
    nCmp++; if (seen !== 1'b0) begin nBad++; $display("[TB] FAIL abort response: got a response want none"); end
    runOp(tbl[1], oAck, oErr, oLat, oDat, oStuck);
    e = sbq.pop_front();
    nCmp++; if ({oAck, oErr} !== {!e.isErr, e.isErr}) begin nBad++; $display("[TB] FAIL %s resp: got ack=%0b err=%0b want ack=%0b err=%0b", e.name, oAck, oErr, !e.isErr, e.isErr); end
    nCmp++; if (oDat !== e.data) begin nBad++; $display("[TB] FAIL %s dat_o after abort: got %h want %h", e.name, oDat, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit expAck;
    logic [31:0] want;
    want = mdl.exists(4) ? mdl[4] : 32'h0;
    for (int k = 0; k < 4; k++) sbq.push_back('{0, 1, want, "u0 b2b rd @10"});
    lastRd[0] = want;
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      expAck = (c % 2 == 1);
      if (c == 8) applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      nCmp++; if (busA.ack_o !== expAck) begin nBad++; $display("[TB] FAIL b2b cycle %0d ack_o: got %0b want %0b", c, busA.ack_o, expAck); end
      if (busA.ack_o === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        nCmp++; if (busA.dat_o !== e.data) begin nBad++; $display("[TB] FAIL %s dat_o: got %h want %h", e.name, busA.dat_o, e.data); end
      end
    end
    nCmp++; if (sbq.size() !== 0) begin nBad++; $display("[TB] FAIL b2b ack count: %0d responses missing want 0", sbq.size()); end
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic test_parity();
`ifdef WB_DMEM_PARITY_EN
    op_t wr;
    bit oAck, oErr, oStuck; int oLat; logic [31:0] oDat; exp_t e;
    logic [3:0] p;
    wr = '{2'd0, 1'b1, 32'h20, 4'hF, 32'h00CC0011};
    runOp(wr, oAck, oErr, oLat, oDat, oStuck);
    e = sbq.pop_front();
    nCmp++; if (oAck !== 1'b1) begin nBad++; $display("[TB] FAIL parity setup write: got ack=%0b want 1", oAck); end
    p = uA.u_ram.r_par[8];
    force uA.u_ram.r_par[8] = p ^ 4'b0100;
    runXfer(0, 1'b0, 32'h20, 4'h4, 32'h0, oAck, oErr, oLat, oDat, oStuck);
    nCmp++; if ({oAck, oErr} !== 2'b01) begin nBad++; $display("[TB] FAIL parity lane2: got ack=%0b err=%0b want err", oAck, oErr); end
    nCmp++; if (oDat !== 32'h00CC0011) begin nBad++; $display("[TB] FAIL parity lane2 dat_o: got %h want 00cc0011", oDat); end
    runXfer(0, 1'b0, 32'h20, 4'h1, 32'h0, oAck, oErr, oLat, oDat, oStuck);
    nCmp++; if ({oAck, oErr} !== 2'b10) begin nBad++; $display("[TB] FAIL parity lane0: got ack=%0b err=%0b want ack", oAck, oErr); end
    release uA.u_ram.r_par[8];
    lastRd[0] = 32'h00CC0011;
`endif
  endtask

  task automatic test_reset_mid_wait();
    op_t tbl[3];
    bit oAck, oErr, oStuck, a, er; int oLat; logic [31:0] oDat, d; exp_t e;
    tbl = '{ '{2'd1, 1'b1, 32'h1010, 4'hF, 32'h76543210},
             '{2'd1, 1'b0, 32'h1010, 4'hF, 32'h0},
             '{2'd1, 1'b0, 32'h1010, 4'hF, 32'h0} };
    for (int i = 0; i < 2; i++) begin
      runOp(tbl[i], oAck, oErr, oLat, oDat, oStuck);
      e = sbq.pop_front();
      nCmp++; if (oDat !== e.data) begin nBad++; $display("[TB] FAIL %s dat_o: got %h want %h", e.name, oDat, e.data); end
    end
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h1010, 4'hF, 32'hBAD0BAD0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h1010, 4'hF, 32'hBAD0BAD0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    sampleBus(1, a, er, d);
    nCmp++; if (a !== 1'b0) begin nBad++; $display("[TB] FAIL mid-wait reset ack_o: got %0b want 0", a); end
    nCmp++; if (er !== 1'b0) begin nBad++; $display("[TB] FAIL mid-wait reset err_o: got %0b want 0", er); end
    nCmp++; if (d !== 32'h0) begin nBad++; $display("[TB] FAIL mid-wait reset dat_o: got %h want 0", d); end
    lastRd[0] = 32'h0;
    lastRd[1] = 32'h0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runOp(tbl[2], oAck, oErr, oLat, oDat, oStuck);
    e = sbq.pop_front();
    nCmp++; if ({oAck, oErr} !== {!e.isErr, e.isErr}) begin nBad++; $display("[TB] FAIL %s resp after reset: got ack=%0b err=%0b", e.name, oAck, oErr); end
    nCmp++; if (oLat !== e.lat) begin nBad++; $display("[TB] FAIL %s latency after reset: got %0d want %0d", e.name, oLat, e.lat); end
    nCmp++; if (oDat !== e.data) begin nBad++; $display("[TB] FAIL %s pending write leaked: got %h want %h", e.name, oDat, e.data); end
  endtask

  initial begin
    nCmp = 0;
    nBad = 0;
    $display("[TB] starting wb_dmem_ctrl bench");
    test_reset();
    test_write_read();
    test_wait_states();
    test_range();
    test_abort();
    test_back_to_back();
    test_parity();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
